// File: rtl/lif_integrator.sv
// -----------------------------------------------------------------------------
// lif_integrator
//
// Leaky integrate-and-fire stage that sits after the plastic neuron. Each
// enabled cycle the signed upstream product is scaled down, added to a leaky
// membrane potential, and compared against a firing threshold. A crossing
// produces a one-cycle spike, resets the membrane and starts a refractory
// period. Over fixed windows of enabled cycles the stage counts its own spikes
// and the teacher's spikes and returns a scaled, saturated difference as
// feedback_error for the upstream learning port.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous, active-low reset
//   enable         1 = advance state, 0 = freeze every register
//   in_valid       qualifier for in_data
//   in_data        signed 32-bit product from the upstream neuron
//   target_spike   teacher spike, sampled on every enabled cycle
//   spike_out      one-cycle spike pulse (registered)
//   membrane       signed membrane potential (registered)
//   refractory     high while the neuron is refractory
//   feedback_error signed 16-bit (target - actual) << ERR_SHIFT, saturated
//   error_valid    one-cycle qualifier for feedback_error
// -----------------------------------------------------------------------------
module lif_integrator #(
   parameter int IN_SHIFT       = 8,
   parameter int LEAK_SHIFT     = 4,
   parameter int THRESHOLD      = 1000,
   parameter int V_RESET        = 0,
   parameter int REFRACT_CYCLES = 4,
   parameter int WINDOW         = 64,
   parameter int ERR_SHIFT      = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   input  logic        target_spike,
   output logic        spike_out,
   output logic [31:0] membrane,
   output logic        refractory,
   output logic [15:0] feedback_error,
   output logic        error_valid
);

   typedef enum logic {
      INTEGRATE  = 1'b0,
      REFRACTORY = 1'b1
   } state_t;

   localparam int WIN_W = $clog2(WINDOW);
   localparam int RC_W  = $clog2(REFRACT_CYCLES + 1);

   // Two guard bits keep membrane - leak + add exact before clamping.
   localparam logic signed [33:0] THR   = 34'(THRESHOLD);
   localparam logic signed [33:0] FLOOR = -THR;
   localparam logic signed [33:0] CEIL  = 34'sh0_7FFF_FFFF;
   localparam logic        [31:0] V_RST = 32'(V_RESET);

   state_t            state;
   logic [RC_W-1:0]   refr_cnt;
   logic [WIN_W-1:0]  win_cnt;
   logic [7:0]        act_cnt;
   logic [7:0]        tgt_cnt;

   logic signed [33:0] mem_ext;
   logic signed [33:0] add_term;
   logic signed [33:0] v_raw;
   logic signed [33:0] v_clamped;
   logic               fire;
   logic               win_close;
   logic [7:0]         act_next;
   logic [7:0]         tgt_next;
   logic signed [31:0] diff;
   logic [15:0]        err_sat;

   // NOTE: every signal gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      mem_ext   = {{2{membrane[31]}}, membrane};
      add_term  = '0;
      if (in_valid) begin
         add_term = $signed({{2{in_data[31]}}, in_data}) >>> IN_SHIFT;
      end
      v_raw     = mem_ext - (mem_ext >>> LEAK_SHIFT) + add_term;

      v_clamped = v_raw;
      if (v_raw < FLOOR) begin
         v_clamped = FLOOR;
      end else if (v_raw > CEIL) begin
         v_clamped = CEIL;
      end

      // A spike decision only exists while integrating; the refractory
      // state discards the input entirely.
      fire      = (state == INTEGRATE) && (v_clamped >= THR);
      win_close = (win_cnt == WIN_W'(WINDOW - 1));

      // Counts include this cycle's events, saturating at 255.
      act_next  = act_cnt;
      if (fire && (act_cnt != 8'hFF)) begin
         act_next = act_cnt + 8'd1;
      end
      tgt_next  = tgt_cnt;
      if (target_spike && (tgt_cnt != 8'hFF)) begin
         tgt_next = tgt_cnt + 8'd1;
      end

      diff      = ($signed({24'd0, tgt_next}) - $signed({24'd0, act_next})) <<< ERR_SHIFT;
      err_sat   = diff[15:0];
      if (diff > 32'sd32767) begin
         err_sat = 16'h7FFF;
      end else if (diff < -32'sd32768) begin
         err_sat = 16'h8000;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= INTEGRATE;
         membrane       <= V_RST;
         refr_cnt       <= '0;
         win_cnt        <= '0;
         act_cnt        <= '0;
         tgt_cnt        <= '0;
         spike_out      <= 1'b0;
         refractory     <= 1'b0;
         feedback_error <= '0;
         error_valid    <= 1'b0;
      end else if (!enable) begin
         // Frozen: every register holds, only the pulses are squashed.
         spike_out   <= 1'b0;
         error_valid <= 1'b0;
      end else begin
         spike_out   <= 1'b0;
         error_valid <= 1'b0;

         // Window bookkeeping. The closing cycle's own events belong to the
         // closing window, so the counts restart from zero afterwards.
         if (win_close) begin
            win_cnt        <= '0;
            feedback_error <= err_sat;
            error_valid    <= 1'b1;
            act_cnt        <= '0;
            tgt_cnt        <= '0;
         end else begin
            win_cnt <= win_cnt + 1'b1;
            act_cnt <= act_next;
            tgt_cnt <= tgt_next;
         end

         case (state)
            INTEGRATE: begin
               if (fire) begin
                  membrane   <= V_RST;
                  spike_out  <= 1'b1;
                  state      <= REFRACTORY;
                  refractory <= 1'b1;
                  refr_cnt   <= RC_W'(REFRACT_CYCLES);
               end else begin
                  membrane <= v_clamped[31:0];
               end
            end
            REFRACTORY: begin
               // Membrane is pinned at V_RESET: no leak, no accumulation.
               membrane <= V_RST;
               if (refr_cnt == RC_W'(1)) begin
                  state      <= INTEGRATE;
                  refractory <= 1'b0;
                  refr_cnt   <= '0;
               end else begin
                  refr_cnt <= refr_cnt - 1'b1;
               end
            end
            default: begin
               state <= INTEGRATE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lif_integrator.sv
// -----------------------------------------------------------------------------
// tb_lif_integrator
//
// Directed bench for lif_integrator at default parameters. The driver applies
// one vector per clock, advances a behavioural reference model and pushes the
// expected post-edge outputs into a scoreboard queue; window-close results go
// into a second queue. An independent monitor pops and compares every cycle,
// and pops the error queue whenever error_valid is presented. The driver also
// checks hand-computed values at the points of interest.
// -----------------------------------------------------------------------------
module tb_lif_integrator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        in_valid;
   logic [31:0] in_data;
   logic        target_spike;
   logic        spike_out;
   logic [31:0] membrane;
   logic        refractory;
   logic [15:0] feedback_error;
   logic        error_valid;

   always #5 clk = ~clk;

   lif_integrator dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .target_spike   (target_spike),
      .spike_out      (spike_out),
      .membrane       (membrane),
      .refractory     (refractory),
      .feedback_error (feedback_error),
      .error_valid    (error_valid)
   );

   typedef struct packed {
      logic [31:0] mem;
      logic        spike;
      logic        refr;
      logic        ev;
      logic [15:0] fb;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] err_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [31:0] POS_IN = 32'd25600;
   localparam logic [31:0] NEG_IN = -32'sd25600;
   localparam logic [31:0] BIG_IN = 32'h7FFF_0000;

   task automatic check(input string name, input logic signed [63:0] got,
                        input logic signed [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
   endtask

   // ---------------- reference model (default parameters) ----------------
   longint      m_mem;
   bit          m_in_refr;
   int          m_rcnt, m_win, m_act, m_tgt;
   logic [15:0] m_fb;
   bit          m_spike, m_ev;

   task automatic model_step(input bit r, input bit en, input bit iv,
                             input logic [31:0] d, input bit tg, output exp_t e);
      longint add, v, dd;
      bit     fire;
      fire = 1'b0;
      if (!r) begin
         m_mem = 0; m_in_refr = 0; m_rcnt = 0; m_win = 0;
         m_act = 0; m_tgt = 0; m_fb = '0; m_spike = 0; m_ev = 0;
      end else if (!en) begin
         m_spike = 0; m_ev = 0;
      end else begin
         m_ev = 0;
         if (!m_in_refr) begin
            add = iv ? (longint'($signed(d)) >>> 8) : 0;
            v   = m_mem - (m_mem >>> 4) + add;
            if (v < -1000) v = -1000;
            if (v > 64'sd2147483647) v = 64'sd2147483647;
            if (v >= 1000) begin
               fire = 1'b1; m_mem = 0; m_in_refr = 1; m_rcnt = 4;
            end else begin
               m_mem = v;
            end
         end else if (m_rcnt == 1) begin
            m_in_refr = 0; m_rcnt = 0;
         end else begin
            m_rcnt--;
         end
         if (fire && m_act < 255) m_act++;
         if (tg && m_tgt < 255) m_tgt++;
         if (m_win == 63) begin
            dd = longint'(m_tgt - m_act) * 16;
            if (dd > 32767) dd = 32767;
            if (dd < -32768) dd = -32768;
            m_fb = dd[15:0];
            m_ev = 1;
            err_q.push_back(m_fb);
            m_act = 0; m_tgt = 0; m_win = 0;
         end else begin
            m_win++;
         end
         m_spike = fire;
      end
      e.mem   = m_mem[31:0];
      e.spike = m_spike;
      e.refr  = m_in_refr;
      e.ev    = m_ev;
      e.fb    = m_fb;
   endtask

   // One clock: drive at negedge, predict, return 1 time unit after posedge.
   task automatic step(input bit r, input bit en, input bit iv,
                       input logic [31:0] d, input bit tg);
      exp_t e;
      @(negedge clk);
      rst_n = r; enable = en; in_valid = iv; in_data = d; target_spike = tg;
      model_step(r, en, iv, d, tg, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0) continue;
         e = exp_q.pop_front();
         check("membrane", $signed(membrane), $signed(e.mem));
         check("spike_out", spike_out, e.spike);
         check("refractory", refractory, e.refr);
         check("error_valid", error_valid, e.ev);
         check("feedback_hold", $signed(feedback_error), $signed(e.fb));
         if (error_valid === 1'b1) begin
            if (err_q.size() == 0) check("unexpected_error_valid", 1, 0);
            else check("feedback_error", $signed(feedback_error), $signed(err_q.pop_front()));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not finish");
   end

   // ---------------- driver ----------------
   int exp_mem[16] = '{100, 194, 282, 365, 443, 516, 584, 648,
                       708, 764, 817, 866, 912, 955, 996, 0};

   initial begin : driver
      bit tg;
      rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1; in_data = POS_IN; target_spike = 1'b0;

      // Reset dominates live input.
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, POS_IN, 0);
         check("rst_membrane", $signed(membrane), 0);
         check("rst_spike", spike_out, 0);
         check("rst_error_valid", error_valid, 0);
      end

      // Window 0: two spikes, five teacher pulses -> +48.
      for (int i = 0; i < 64; i++) begin
         tg = (i == 2 || i == 10 || i == 30 || i == 40 || i == 50);
         step(1, 1, (i <= 35), POS_IN, tg);
         if (i < 16) check("fire_seq", $signed(membrane), exp_mem[i]);
         if (i == 14) check("pre_fire_spike", spike_out, 0);
         if (i == 15) check("fire_spike", spike_out, 1);
         if (i == 16) check("spike_one_cycle", spike_out, 0);
         if (i >= 15 && i <= 18) begin
            check("refr_high", refractory, 1);
            check("refr_mem", $signed(membrane), 0);
         end
         if (i == 19) check("refr_low", refractory, 0);
         if (i == 20) check("post_refr_mem", $signed(membrane), 100);
         if (i == 35) check("second_spike", spike_out, 1);
         if (i == 62) check("no_early_ev", error_valid, 0);
      end
      check("win0_ev", error_valid, 1);
      check("win0_fb", $signed(feedback_error), 48);

      // Window 1: negative floor, no teacher, no spikes -> 0.
      for (int i = 0; i < 64; i++) begin
         step(1, 1, (i < 40), NEG_IN, 0);
         if (i == 0) begin
            check("ev_pulse_single", error_valid, 0);
            check("fb_holds", $signed(feedback_error), 48);
         end
         if (i < 40) check("floor_bound", ($signed(membrane) >= -1000), 1);
         if (i == 39) check("floor_value", $signed(membrane), -1000);
      end
      check("win1_fb", $signed(feedback_error), 0);

      // Window 2: three spikes, no teacher -> -48.
      for (int i = 0; i < 64; i++) begin
         step(1, 1, (i <= 10), BIG_IN, 0);
         if (i == 0 || i == 5 || i == 10) check("big_spike", spike_out, 1);
      end
      check("win2_ev", error_valid, 1);
      check("win2_fb", $signed(feedback_error), -48);

      // Window 3: freeze mid-integration, then reset while refractory at pos 63.
      for (int i = 0; i < 5; i++) step(1, 1, 1, POS_IN, 0);
      check("pre_freeze_mem", $signed(membrane), 443);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 1, BIG_IN, 1);
         check("freeze_mem", $signed(membrane), 443);
         check("freeze_spike", spike_out, 0);
      end
      for (int i = 5; i < 63; i++) begin
         step(1, 1, (i == 61), BIG_IN, (i == 20));
         if (i == 61) check("pre_reset_spike", spike_out, 1);
         if (i == 62) check("pre_reset_refr", refractory, 1);
      end
      step(0, 1, 1, BIG_IN, 1);
      check("reset_no_ev", error_valid, 0);
      check("reset_refr", refractory, 0);
      check("reset_mem", $signed(membrane), 0);
      check("reset_fb", $signed(feedback_error), 0);

      // Fresh window after reset: one teacher pulse only -> +16.
      for (int i = 0; i < 64; i++) begin
         step(1, 1, (i == 0), POS_IN, (i == 7));
         if (i == 0) check("post_reset_integrate", $signed(membrane), 100);
      end
      check("win4_ev", error_valid, 1);
      check("win4_fb", $signed(feedback_error), 16);

      step(1, 1, 0, 32'd0, 0);
      step(1, 1, 0, 32'd0, 0);
      #5;
      check("exp_q_drained", exp_q.size(), 0);
      check("err_q_drained", err_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lif_integrator.md
Name: lif_integrator

Overview:
- Downstream stage of the plastic neuron. Consumes its signed 32-bit weighted product and integrates it into a leaky membrane potential.
- Emits a one-cycle spike when the threshold is crossed, then enforces a refractory period.
- Once per evaluation window, compares the spike count against a teacher spike train and returns a signed 16-bit feedback_error to the upstream neuron's learning port.

Parameters:
- IN_SHIFT, 8: arithmetic right shift applied to in_data before integration.
- LEAK_SHIFT, 4: leak per cycle is membrane >>> LEAK_SHIFT.
- THRESHOLD, 1000: signed firing threshold, positive; the membrane floor is -THRESHOLD.
- V_RESET, 0: membrane value after a spike; must lie in [-THRESHOLD, THRESHOLD).
- REFRACT_CYCLES, 4: cycles spent in REFRACTORY after a spike, ≥1.
- WINDOW, 64: enabled cycles per error-evaluation window, ≥2.
- ERR_SHIFT, 4: left shift applied to the spike-count difference.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  1 = advance state; 0 = freeze all state
- in_valid  in  1  in_data qualifier
- in_data  in  32  signed product from the upstream neuron
- target_spike  in  1  teacher spike, sampled each enabled cycle
- spike_out  out  1  one-cycle spike pulse
- membrane  out  32  signed membrane potential, registered
- refractory  out  1  high while in REFRACTORY
- feedback_error  out  16  signed error to the upstream neuron
- error_valid  out  1  one-cycle qualifier for feedback_error

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=INTEGRATE, membrane=V_RESET.
  - spike_out=0, refractory=0, feedback_error=0, error_valid=0.
  - Window counter, actual-spike count and target-spike count all cleared.
  - Reset overrides everything, including mid-refractory and the window-closing cycle; no error_valid is emitted for a partial window.
- enable=0:
  - All registers hold, including the window counter and the refractory counter.
  - spike_out and error_valid are forced 0.
  - in_valid and target_spike are ignored.
- State INTEGRATE (enable=1):
  - Compute in 34-bit signed: add = in_valid ? (in_data >>> IN_SHIFT) : 0; v = membrane - (membrane >>> LEAK_SHIFT) + add.
  - Clamp v to [-THRESHOLD, 2^31-1].
  - If v ≥ THRESHOLD: membrane <= V_RESET, spike_out <= 1 (next cycle only), state <= REFRACTORY, refractory counter <= REFRACT_CYCLES.
  - Otherwise: membrane <= v, spike_out <= 0.
  - Latency from the crossing input to spike_out is 1 cycle.
- State REFRACTORY (enable=1):
  - in_data is discarded and membrane holds V_RESET; there is no leak and no accumulation.
  - refractory=1 for exactly REFRACT_CYCLES enabled cycles, then state <= INTEGRATE.
  - The first integrating input is the one presented on the cycle after refractory deasserts.
- Window counter (enable=1):
  - Increments every enabled cycle and wraps at WINDOW-1 to 0.
  - Counts saturate at 255 (8-bit).
  - The actual-spike count increments on each spike decision (the same edge at which spike_out is set).
  - The target count increments when target_spike=1.
- Window close: on the enabled cycle where the counter equals WINDOW-1 (this cycle's events are included):
  - Register d = (target_count - actual_count) << ERR_SHIFT, saturated to [-32768, 32767], into feedback_error.
  - Pulse error_valid=1 for the next cycle.
  - Clear both counts, then apply this cycle's own events to the new window? No: this cycle's events belong to the closing window; both counts are 0 at the start of the next window.
- feedback_error holds its value between windows. error_valid is a single-cycle pulse.
- Simultaneous spike and window close: the spike counts in the closing window. The refractory period continues across the window boundary.
- Arithmetic right shifts round toward −∞; for example, -25601 >>> 8 = -101.

Test Plan:
- Reset and hold: drive rst_n=0 for 3 cycles with in_valid=1 and in_data=25600 → membrane=0, spike_out=0, error_valid=0 throughout and on the first cycle after release.
- Integrate to fire (defaults): enable=1, in_valid=1, in_data=25600 (+100 per cycle) → membrane sequence 100, 194, 282, 365, …, 955, 996; the 16th input produces spike_out=1 for one cycle and membrane=0.
- Refractory: continue the same stimulus after the spike → refractory=1 for 4 cycles with membrane=0; the next input gives membrane=100.
- Negative floor: in_data=-25600 for 40 cycles → membrane clamps at -1000 and never goes below it; spike_out stays 0.
- Error window: 5 target_spike pulses and exactly 2 actual spikes within one 64-cycle window → on the cycle after the window closes, error_valid=1 and feedback_error=48. Mirror case with 0 targets and 3 spikes → feedback_error=-48.
- Freeze and reset mid-operation:
  - enable=0 for 10 cycles mid-integration → membrane and the window position are unchanged.
  - Assert rst_n=0 during REFRACTORY at window cycle 63 → no error_valid, state returns to INTEGRATE, all counts cleared.
